// File: rtl/bit_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bit_serializer: WIDTH-bit word in over valid/ready, one bit per clock    |
// | out on w, with optional idle gap after each word.  Rev 1.0               |
// +--------------------------------------------------------------------------+
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter int GAP       = 0,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             w,
  output logic             w_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST_IDX = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [7:0]     GAP_INIT = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [7:0]       gap_q, gap_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic             w_q, w_d;
  logic             w_valid_q, w_valid_d;
  logic             word_done_q, word_done_d;

  logic             w_first;
  logic [WIDTH-1:0] load_rest;
  logic             w_next;
  logic [WIDTH-1:0] shift_rest;
  logic [CW-1:0]    cnt_inc;
  logic             last_bit;
  logic             transfer;

  // The first bit goes straight to w on the load edge, so the shift register
  // only ever holds the bits still to come.
  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign w_first    = data_in[WIDTH-1];
      assign load_rest  = {data_in[WIDTH-2:0], 1'b0};
      assign w_next     = sreg_q[WIDTH-1];
      assign shift_rest = {sreg_q[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign w_first    = data_in[0];
      assign load_rest  = {1'b0, data_in[WIDTH-1:1]};
      assign w_next     = sreg_q[0];
      assign shift_rest = {1'b0, sreg_q[WIDTH-1:1]};
    end
  endgenerate

  assign cnt_inc    = cnt_q + CNT_ONE;
  assign last_bit   = (state_q == S_SHIFT) && (cnt_q == LAST_IDX);
  assign data_ready = !reset && ((state_q == S_IDLE) || (last_bit && (GAP == 0)));
  assign transfer   = data_valid && data_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gap_d       = gap_q;
    sreg_d      = sreg_q;
    w_d         = 1'b0;
    w_valid_d   = 1'b0;
    word_done_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
      end
      S_SHIFT: begin
        if (!last_bit) begin
          cnt_d       = cnt_inc;
          sreg_d      = shift_rest;
          w_d         = w_next;
          w_valid_d   = 1'b1;
          word_done_d = (cnt_inc == LAST_IDX);
        end else if (GAP > 0) begin
          state_d = S_GAP;
          gap_d   = GAP_INIT;
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      S_GAP: begin
        if (gap_q == 8'd0) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // A load overrides whatever the state logic chose, including the
    // back-to-back case on the last bit of a word.
    if (transfer) begin
      state_d   = S_SHIFT;
      cnt_d     = '0;
      sreg_d    = load_rest;
      w_d       = w_first;
      w_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      gap_q       <= 8'd0;
      sreg_q      <= '0;
      w_q         <= 1'b0;
      w_valid_q   <= 1'b0;
      word_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gap_q       <= gap_d;
      sreg_q      <= sreg_d;
      w_q         <= w_d;
      w_valid_q   <= w_valid_d;
      word_done_q <= word_done_d;
    end
  end

  assign w         = w_q;
  assign w_valid   = w_valid_q;
  assign word_done = word_done_q;
  assign busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_bit_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_bit_serializer: directed checks of three serializer configurations.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_bit_serializer;

  logic clk;
  logic reset;

  logic [7:0] din0, din1, din2;
  logic       dv0, dv1, dv2;
  logic       rdy0, rdy1, rdy2;
  logic       w0, w1, w2;
  logic       wv0, wv1, wv2;
  logic       wd0, wd1, wd2;
  logic       busy0, busy1, busy2;

  int n_assert = 0;
  int n_fail   = 0;

  bit_serializer #(.WIDTH(8), .GAP(0), .MSB_FIRST(1)) u0 (
    .clk(clk), .reset(reset), .data_in(din0), .data_valid(dv0),
    .data_ready(rdy0), .w(w0), .w_valid(wv0), .word_done(wd0), .busy(busy0)
  );

  bit_serializer #(.WIDTH(8), .GAP(2), .MSB_FIRST(1)) u1 (
    .clk(clk), .reset(reset), .data_in(din1), .data_valid(dv1),
    .data_ready(rdy1), .w(w1), .w_valid(wv1), .word_done(wd1), .busy(busy1)
  );

  bit_serializer #(.WIDTH(8), .GAP(0), .MSB_FIRST(0)) u2 (
    .clk(clk), .reset(reset), .data_in(din2), .data_valid(dv2),
    .data_ready(rdy2), .w(w2), .w_valid(wv2), .word_done(wd2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0]  v;
    logic [15:0] v16;

    // Reset held across two edges with a word already offered
    reset = 1'b1;
    dv0 = 1'b1; din0 = 8'h5B;
    dv1 = 1'b0; din1 = 8'h00;
    dv2 = 1'b0; din2 = 8'h00;
    #1;
    check("rst_w0", w0, 0);
    check("rst_wv0", wv0, 0);
    check("rst_wd0", wd0, 0);
    check("rst_busy0", busy0, 0);
    check("rst_rdy0", rdy0, 0);
    check("rst_rdy1", rdy1, 0);
    check("rst_busy1", busy1, 0);
    check("rst_rdy2", rdy2, 0);
    tick();
    check("rst_edge1_busy0", busy0, 0);
    check("rst_edge1_wv0", wv0, 0);
    tick();
    check("rst_edge2_busy0", busy0, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("release_rdy0", rdy0, 1);
    check("release_busy0", busy0, 0);

    // Single word 8'h5B, MSB first; data_in changed right after the load
    tick();
    dv0 = 1'b0; din0 = 8'h00;
    v = 8'h5B;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("single_w[%0d]", i), w0, v[7-i]);
      check($sformatf("single_wv[%0d]", i), wv0, 1);
      check($sformatf("single_wd[%0d]", i), wd0, (i == 7));
      check($sformatf("single_rdy[%0d]", i), rdy0, (i == 7));
      check($sformatf("single_busy[%0d]", i), busy0, 1);
      tick();
    end
    check("single_idle_w", w0, 0);
    check("single_idle_wv", wv0, 0);
    check("single_idle_busy", busy0, 0);
    check("single_idle_rdy", rdy0, 1);

    // Back-to-back 8'hA5 then 8'h3C with valid held
    din0 = 8'hA5; dv0 = 1'b1;
    tick();
    din0 = 8'h3C;
    v16 = 16'hA53C;
    for (int i = 0; i < 16; i++) begin
      if (i == 8) begin
        dv0 = 1'b0; din0 = 8'h00;
      end
      check($sformatf("b2b_w[%0d]", i), w0, v16[15-i]);
      check($sformatf("b2b_wv[%0d]", i), wv0, 1);
      check($sformatf("b2b_wd[%0d]", i), wd0, (i == 7 || i == 15));
      check($sformatf("b2b_rdy[%0d]", i), rdy0, (i == 7 || i == 15));
      tick();
    end
    check("b2b_end_wv", wv0, 0);
    check("b2b_end_busy", busy0, 0);

    // GAP=2: two 8'hFF words, valid held throughout the gap
    din1 = 8'hFF; dv1 = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      check($sformatf("gap_w[%0d]", i), w1, 1);
      check($sformatf("gap_wv[%0d]", i), wv1, 1);
      check($sformatf("gap_wd[%0d]", i), wd1, (i == 7));
      check($sformatf("gap_rdy[%0d]", i), rdy1, 0);
      tick();
    end
    for (int g = 0; g < 2; g++) begin
      check($sformatf("gap_idle_w[%0d]", g), w1, 0);
      check($sformatf("gap_idle_wv[%0d]", g), wv1, 0);
      check($sformatf("gap_idle_rdy[%0d]", g), rdy1, 0);
      check($sformatf("gap_idle_busy[%0d]", g), busy1, 1);
      tick();
    end
    check("gap_ready_cycle_rdy", rdy1, 1);
    check("gap_ready_cycle_busy", busy1, 0);
    check("gap_ready_cycle_wv", wv1, 0);
    tick();
    dv1 = 1'b0;
    check("gap_second_w", w1, 1);
    check("gap_second_wv", wv1, 1);
    check("gap_second_busy", busy1, 1);

    // LSB first: 8'h01 gives a single leading one
    din2 = 8'h01; dv2 = 1'b1;
    tick();
    dv2 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("lsb_w[%0d]", i), w2, (i == 0));
      check($sformatf("lsb_wv[%0d]", i), wv2, 1);
      check($sformatf("lsb_wd[%0d]", i), wd2, (i == 7));
      tick();
    end
    check("lsb_end_wv", wv2, 0);

    // Reset in the middle of 8'hF0, then a clean 8'h81
    din0 = 8'hF0; dv0 = 1'b1;
    tick();
    dv0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("mid_w[%0d]", i), w0, 1);
      check($sformatf("mid_wv[%0d]", i), wv0, 1);
      if (i < 2) tick();
    end
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_w", w0, 0);
    check("mid_rst_wv", wv0, 0);
    check("mid_rst_wd", wd0, 0);
    check("mid_rst_busy", busy0, 0);
    check("mid_rst_rdy", rdy0, 0);
    @(negedge clk);
    reset = 1'b0;
    din0 = 8'h81; dv0 = 1'b1;
    #1;
    check("mid_release_rdy", rdy0, 1);
    check("mid_release_busy", busy0, 0);
    check("mid_release_wv", wv0, 0);
    tick();
    dv0 = 1'b0;
    v = 8'h81;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("after_rst_w[%0d]", i), w0, v[7-i]);
      check($sformatf("after_rst_wv[%0d]", i), wv0, 1);
      check($sformatf("after_rst_wd[%0d]", i), wd0, (i == 7));
      tick();
    end
    check("after_rst_end_wv", wv0, 0);
    check("after_rst_end_busy", busy0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
